fsqrt_share_arbiter: RTL and testbench
======================================

// Module: fsqrt_share_arbiter
// PURPOSE
//  Shares one pipelined Float_Sqrt unit (fixed latency, pipe flushed whenever en=0) among NUM_REQ
//  requesters (shader ALU lanes) in the RT core. Round-robin arbitrates one issue per cycle and
//  drives the unit's en/a registered. Tags each op with its requester and routes results back.
//  Holds en high until the pipe drains so in-flight ops are never flushed.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2)
//  SQ_LAT   5  Float_Sqrt register depth (q valid SQ_LAT edges after en/a applied)
// PORTS
//  clk          in   1          clock
//  areset       in   1          reset, asynchronous, active-high
//  req_valid    in   NUM_REQ    per-requester op valid; operand must be held until accepted
//  req_a        in   NUM_REQ*32 per-requester IEEE-754 single operand, slice i = [32*i+:32]
//  req_ready    out  NUM_REQ    one-hot grant; handshake = req_valid[i] & req_ready[i]
//  flush        in   1          synchronous abort of all in-flight ops
//  resp_valid   out  NUM_REQ    one-hot, 1-cycle pulse per result (no backpressure)
//  resp_data    out  32         result, shared by all requesters, valid with resp_valid
//  resp_nan     out  1          result was forced to NaN (tied 0 without FSQRT_NEG_NAN_EN)
//  sqrt_en      out  1          to Float_Sqrt.en (registered)
//  sqrt_a       out  32         to Float_Sqrt.a (registered)
//  sqrt_q       in   32         from Float_Sqrt.q
//  busy         out  1          any op in flight or in output stage
// BEHAVIOUR
//  - Reset: req_ready=0, resp_valid=0, resp_data=0, resp_nan=0, sqrt_en=0, sqrt_a=0, busy=0,
//    rr pointer=0, tag pipe cleared, state=IDLE. Reset mid-operation drops all ops silently.
//  - Arbitration: combinational round-robin over req_valid starting at rr pointer. req_ready is
//    one-hot for the winner only, else 0. After a grant to i, the pointer becomes (i+1) mod
//    NUM_REQ. With no grant the pointer holds. req_ready=0 while flush=1.
//  - Issue: on handshake at edge E0, sqrt_a<=req_a[i] and a tag {v=1,id=i} enters tag stage 0.
//    Without a handshake, sqrt_a<=0 and a bubble tag {v=0} enters stage 0.
//  - Tag pipe: SQ_LAT+1 stages, advanced every edge while sqrt_en=1, so each tag stays aligned
//    with its data.
//  - Output: at edge E0+SQ_LAT+1, resp_data<=sqrt_q and resp_valid<=onehot(id) if tag v=1.
//    Latency is SQ_LAT+1 edges from handshake to resp_valid (6 at defaults).
//    Throughput is 1 op/cycle. Back-to-back results from the same requester are allowed.
//  - FSM (registered):
//      IDLE   sqrt_en=0. Goes to ACTIVE on any handshake.
//      ACTIVE sqrt_en=1. Goes to DRAIN when no handshake occurs and at least one tag is valid.
//      DRAIN  sqrt_en=1. Returns to ACTIVE on a handshake. Goes to IDLE on the edge after the
//             last valid tag is captured to resp.
//    sqrt_en never drops while any tag v=1; bubbles are issued with en=1.
//  - In-flight counter: +1 on handshake, -1 on resp capture, simultaneous = hold.
//    Range 0..SQ_LAT+1; it cannot overflow with one issue per cycle.
//    busy = (count!=0) | (state!=IDLE).
//  - flush=1 at an edge: all tags cleared, count=0, sqrt_en<=0 (pipe zeroed), state<=IDLE,
//    resp_valid<=0 on the following cycle. A handshake in the same cycle is impossible because
//    ready is forced to 0. Requests resume the cycle after flush deasserts.
//  - Simultaneous issue and resp capture in the same cycle are independent; both proceed.
//  - A requester whose req_valid drops before grant loses nothing; no state is kept per requester.
// CONFIGURATION
//  FSQRT_NEG_NAN_EN defined:
//    - The tag carries an extra bit n = a[31] & (a[30:0]!=0) (negative, non-zero operand).
//    - At output, n=1 forces resp_data=32'h7FC0_0000 and resp_nan=1; the op still occupies its
//      pipe slot and latency is unchanged.
//    - -0.0 (32'h8000_0000) is not flagged and passes through.
//  FSQRT_NEG_NAN_EN undefined:
//    - No n bit; resp_data=sqrt_q unmodified; resp_nan tied 0.
// TESTING
//  1. Reset then single op: req_valid[0]=1, a=32'h4080_0000 (4.0) -> ready[0] for 1 cycle;
//     resp_valid=4'b0001 with data 32'h4000_0000 exactly 6 cycles later; busy returns 0.
//  2. All 4 valid for 8 cycles, pointer 0: grants 0,1,2,3,0,1,2,3; results return in the same
//     order, 1/cycle, with correct one-hot ids.
//  3. Gap test: issue on lane 2, idle 3 cycles, issue on lane 1: sqrt_en stays 1 throughout;
//     both results arrive (sqrt 9.0=3.0, 16.0=4.0) with no lost or duplicated resp.
//  4. flush 3 cycles after 2 issues: no resp_valid ever for those ops; sqrt_en=0 next cycle;
//     a new op after flush returns normally at latency 6.
//  5. areset asserted mid-stream with 4 ops in flight: all outputs 0 immediately; no resp after
//     release.
//  6. a=32'hC080_0000 (-4.0) and 32'h8000_0000: with FSQRT_NEG_NAN_EN -> 7FC00000/resp_nan=1,
//     and -0.0 passes with resp_nan=0; without the macro -> raw sqrt_q, resp_nan=0.

Source files
------------

// File: rtl/fsqrt_share_if.sv
// Request/response bus between shader ALU lanes and the shared square-root arbiter.
// Handshake: an op on lane i transfers on a clock edge where req_valid[i] & req_ready[i] is 1.
// req_a lane i must stay stable until that edge. resp_valid is a one-hot, one-cycle pulse and
// cannot be back-pressured. resp_data and resp_nan are meaningful only while resp_valid != 0.
interface fsqrt_share_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [31:0]           resp_data;
    logic                  resp_nan;

    modport master (
        output req_valid, req_a,
        input  req_ready, resp_valid, resp_data, resp_nan
    );

    modport slave (
        input  req_valid, req_a,
        output req_ready, resp_valid, resp_data, resp_nan
    );
endinterface

// File: rtl/fsqrt_share_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined Float_Sqrt among NUM_REQ lanes, with a tag
// pipe that routes results back. Optional macro FSQRT_NEG_NAN_EN forces NaN for negative operands.
module fsqrt_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SQ_LAT  = 5
) (
    input  logic        clk,
    input  logic        areset,
    fsqrt_share_if.slave bus,
    input  logic        flush,
    output logic        sqrt_en,
    output logic [31:0] sqrt_a,
    input  logic [31:0] sqrt_q,
    output logic        busy,
    output logic [1:0]  dbg_state
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(SQ_LAT + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [PW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic               found;
    logic [PW-1:0]      win_id;
    int                 idx;
    logic [31:0]        win_a;
    logic               hs;

    logic [SQ_LAT:0]    tag_v;
    logic [PW-1:0]      tag_id [SQ_LAT+1];
    logic               any_v;
    logic               cap;
    logic [NUM_REQ-1:0] cap_oh;

    logic [CW-1:0]      count;
    logic [NUM_REQ-1:0] resp_valid_q;
    logic [31:0]        resp_data_q;

    // Search starts at rr_ptr and wraps; the first requesting lane wins.
    always_comb begin
        grant  = '0;
        found  = 1'b0;
        win_id = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && bus.req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win_id     = idx[PW-1:0];
            end
        end
    end

    assign bus.req_ready = (flush || areset) ? '0 : grant;
    assign hs            = found & ~flush & ~areset;
    assign win_a         = bus.req_a[int'(win_id)*32 +: 32];

    assign any_v = |tag_v;
    assign cap   = tag_v[SQ_LAT];

    always_comb begin
        cap_oh                 = '0;
        cap_oh[tag_id[SQ_LAT]] = 1'b1;
    end

    // FSM next state; flush always forces IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (hs) state_next = ACTIVE;
            end
            ACTIVE: begin
                if (!hs) state_next = any_v ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (hs)          state_next = ACTIVE;
                else if (!any_v) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

`ifdef FSQRT_NEG_NAN_EN
    logic [SQ_LAT:0] tag_n;
    logic            resp_nan_q;
    logic            win_neg;

    // -0.0 is a legal operand for sqrt and is passed through unflagged.
    assign win_neg = win_a[31] & (|win_a[30:0]);
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rr_ptr       <= '0;
            sqrt_en      <= 1'b0;
            sqrt_a       <= '0;
            tag_v        <= '0;
            count        <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            for (int k = 0; k <= SQ_LAT; k++) begin
                tag_id[k] <= '0;
            end
`ifdef FSQRT_NEG_NAN_EN
            tag_n      <= '0;
            resp_nan_q <= 1'b0;
`endif
        end else if (flush) begin
            sqrt_en      <= 1'b0;
            sqrt_a       <= '0;
            tag_v        <= '0;
            count        <= '0;
            resp_valid_q <= '0;
`ifdef FSQRT_NEG_NAN_EN
            tag_n      <= '0;
            resp_nan_q <= 1'b0;
`endif
        end else begin
            sqrt_en <= (state_next != IDLE);
            sqrt_a  <= hs ? win_a : 32'h0;
            if (hs) begin
                rr_ptr <= (win_id == PW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
            end

            // Stage 0 loads with sqrt_a; later stages move only when the unit's pipe moves.
            tag_v[0]  <= hs;
            tag_id[0] <= win_id;
            for (int k = 1; k <= SQ_LAT; k++) begin
                tag_v[k]  <= sqrt_en ? tag_v[k-1] : 1'b0;
                tag_id[k] <= tag_id[k-1];
            end

            resp_valid_q <= cap ? cap_oh : '0;
            if (cap) begin
`ifdef FSQRT_NEG_NAN_EN
                resp_data_q <= tag_n[SQ_LAT] ? 32'h7FC0_0000 : sqrt_q;
`else
                resp_data_q <= sqrt_q;
`endif
            end

            case ({hs, cap})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

`ifdef FSQRT_NEG_NAN_EN
            tag_n[0] <= hs & win_neg;
            for (int k = 1; k <= SQ_LAT; k++) begin
                tag_n[k] <= sqrt_en ? tag_n[k-1] : 1'b0;
            end
            resp_nan_q <= cap & tag_n[SQ_LAT];
`endif
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
`ifdef FSQRT_NEG_NAN_EN
    assign bus.resp_nan   = resp_nan_q;
`else
    assign bus.resp_nan   = 1'b0;
`endif

    assign busy      = (count != '0) | (state != IDLE);
    assign dbg_state = state;
endmodule

// File: tb/tb_fsqrt_share_arbiter.sv
// Directed bench for fsqrt_share_arbiter with a behavioural Float_Sqrt pipe model and a
// timed response scoreboard.
module tb_fsqrt_share_arbiter;
    localparam int NUM_REQ = 4;
    localparam int SQ_LAT  = 5;

`ifdef FSQRT_NEG_NAN_EN
    localparam logic [31:0] NEG_Q = 32'h7FC0_0000;
    localparam logic        NEG_N = 1'b1;
`else
    localparam logic [31:0] NEG_Q = 32'hFFC0_0000;
    localparam logic        NEG_N = 1'b0;
`endif

    // clock / reset
    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic        flush;
    logic        sqrt_en;
    logic [31:0] sqrt_a;
    logic [31:0] sqrt_q;
    logic        busy;
    logic [1:0]  dbg_state;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fsqrt_share_if #(.NUM_REQ(NUM_REQ)) bus ();

    fsqrt_share_arbiter #(.NUM_REQ(NUM_REQ), .SQ_LAT(SQ_LAT)) dut (
        .clk       (clk),
        .areset    (areset),
        .bus       (bus),
        .flush     (flush),
        .sqrt_en   (sqrt_en),
        .sqrt_a    (sqrt_a),
        .sqrt_q    (sqrt_q),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Float_Sqrt stand-in: table of known roots, SQ_LAT registers, zeroed whenever en=0.
    function automatic logic [31:0] sqrt_fn(input logic [31:0] a);
        case (a)
            32'h4080_0000: return 32'h4000_0000;
            32'h4110_0000: return 32'h4040_0000;
            32'h4180_0000: return 32'h4080_0000;
            32'h3F80_0000: return 32'h3F80_0000;
            32'h41C8_0000: return 32'h40A0_0000;
            32'hC080_0000: return 32'hFFC0_0000;
            32'h8000_0000: return 32'h8000_0000;
            default:       return 32'h0;
        endcase
    endfunction

    logic [31:0] sq_pipe [SQ_LAT];
    always @(posedge clk) begin
        if (sqrt_en) begin
            sq_pipe[0] <= sqrt_fn(sqrt_a);
            for (int k = 1; k < SQ_LAT; k++) sq_pipe[k] <= sq_pipe[k-1];
        end else begin
            for (int k = 0; k < SQ_LAT; k++) sq_pipe[k] <= 32'h0;
        end
    end
    assign sqrt_q = sq_pipe[SQ_LAT-1];

    // scoreboard: {lane[1:0], nan, data} plus the cycle the response must appear
    logic [34:0] exp_q[$];
    int          exp_t_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    logic [34:0] mon_e;
    int          mon_t;
    always @(negedge clk) begin
        if (!areset) begin
            if (exp_t_q.size() != 0 && exp_t_q[0] == cyc) begin
                mon_e = exp_q.pop_front();
                mon_t = exp_t_q.pop_front();
                check_eq("resp_valid", bus.resp_valid, 4'b0001 << mon_e[34:33]);
                check_eq("resp_data", bus.resp_data, mon_e[31:0]);
                check_eq("resp_nan", bus.resp_nan, mon_e[32]);
            end else if (bus.resp_valid != '0) begin
                check_eq("resp_unexpected", bus.resp_valid, 0);
            end
        end
    end

    // driver tasks: each starts and ends 1ns after a rising edge
    task automatic do_reset();
        areset        = 1'b1;
        flush         = 1'b0;
        bus.req_valid = '1;
        exp_q.delete();
        exp_t_q.delete();
        #1;
        check_eq("rst_ready", bus.req_ready, 0);
        check_eq("rst_sqrt_en", sqrt_en, 0);
        check_eq("rst_sqrt_a", sqrt_a, 0);
        check_eq("rst_resp_valid", bus.resp_valid, 0);
        check_eq("rst_resp_data", bus.resp_data, 0);
        check_eq("rst_resp_nan", bus.resp_nan, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_state", dbg_state, 0);
        bus.req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        areset = 1'b0;
    endtask

    task automatic issue(input int lane, input logic [31:0] a,
                         input logic [31:0] exp_d, input logic exp_n);
        int waited = 0;
        bit done = 1'b0;
        bus.req_valid[lane]     = 1'b1;
        bus.req_a[32*lane +: 32] = a;
        while (!done && waited < 20) begin
            @(negedge clk);
            if (bus.req_ready[lane]) begin
                done = 1'b1;
                exp_q.push_back({lane[1:0], exp_n, exp_d});
                exp_t_q.push_back(cyc + SQ_LAT + 2);
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid[lane] = 1'b0;
        check_eq("issue_handshake", done, 1);
    endtask

    task automatic wait_idle(input string tag);
        int waited = 0;
        @(negedge clk);
        while (busy && waited < 30) begin
            waited++;
            @(negedge clk);
        end
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_sqrt_en"}, sqrt_en, 0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] burst_a [8];
    logic [31:0] burst_q [8];

    initial begin
        flush         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        burst_a = '{32'h4080_0000, 32'h4110_0000, 32'h4180_0000, 32'h3F80_0000,
                    32'h41C8_0000, 32'h4080_0000, 32'h4110_0000, 32'h4180_0000};
        burst_q = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h3F80_0000,
                    32'h40A0_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        #2;
        do_reset();

        // single op on lane 0: sqrt(4.0) = 2.0
        issue(0, 32'h4080_0000, 32'h4000_0000, 1'b0);
        wait_idle("single");

        // all lanes requesting from pointer 0: grants rotate 0,1,2,3,0,1,2,3
        do_reset();
        bus.req_valid = '1;
        for (int k = 0; k < 4; k++) bus.req_a[32*k +: 32] = burst_a[k];
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("burst_grant", bus.req_ready, 4'b0001 << (k % 4));
            exp_q.push_back({2'(k % 4), 1'b0, burst_q[k]});
            exp_t_q.push_back(cyc + SQ_LAT + 2);
            @(posedge clk);
            #1;
            if (k < 4) bus.req_a[32*k +: 32] = burst_a[k+4];
        end
        bus.req_valid = '0;
        wait_idle("burst");

        // gap: en must stay high across the idle cycles between the two issues
        issue(2, 32'h4110_0000, 32'h4040_0000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("gap_sqrt_en", sqrt_en, 1);
            @(posedge clk);
            #1;
        end
        issue(1, 32'h4180_0000, 32'h4080_0000, 1'b0);
        wait_idle("gap");

        // flush with two ops in flight; lane 2 waits through the flush and then issues
        issue(0, 32'h4080_0000, 32'h4000_0000, 1'b0);
        issue(1, 32'h4110_0000, 32'h4040_0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b1;
        bus.req_valid[2]     = 1'b1;
        bus.req_a[64 +: 32]  = 32'h4180_0000;
        exp_q.delete();
        exp_t_q.delete();
        @(negedge clk);
        check_eq("flush_ready", bus.req_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        check_eq("flush_sqrt_en", sqrt_en, 0);
        check_eq("flush_resp_valid", bus.resp_valid, 0);
        check_eq("flush_busy", busy, 0);
        issue(2, 32'h4180_0000, 32'h4080_0000, 1'b0);
        wait_idle("post_flush");

        // negative operand and -0.0
        issue(3, 32'hC080_0000, NEG_Q, NEG_N);
        issue(0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_idle("neg");

        // asynchronous reset with four ops in flight; none may come back
        for (int k = 0; k < 4; k++) issue(k, 32'h4080_0000, 32'h4000_0000, 1'b0);
        check_eq("pre_reset_busy", busy, 1);
        do_reset();
        repeat (12) @(posedge clk);
        #1;
        check_eq("post_reset_busy", busy, 0);

        check_eq("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
